// File: rtl/s32x_irl_sched.sv
// rtl/s32x_irl_sched.sv - 32X per-SH2 interrupt scheduler: pending flags, IRL encoder with hold, vector fetch responder
module s32x_irl_sched #(
    parameter int HOLD_MIN = 4,
    parameter int VEC_WAIT = 1,
    parameter int AUTO_CLR = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       CE_R,
    input  logic       CE_F,
    input  logic       EN,
    input  logic       RES_N,
    input  logic [4:0] SRC_EV,
    input  logic [4:0] SRC_MASK,
    input  logic [4:0] SRC_CLR,
    input  logic [7:0] VEC_BASE,
    output logic [4:0] PEND,
    output logic [3:0] IRL_N,
    input  logic [3:0] VBUS_A,
    input  logic       VBUS_REQ,
    output logic [7:0] VBUS_DI,
    output logic       VBUS_WAIT
);

    typedef enum logic [1:0] {V_IDLE, V_WAIT, V_DONE} vstate_t;

    localparam logic [3:0] HOLD_RELOAD = 4'(HOLD_MIN - 1);
    localparam logic [2:0] WAIT_LOAD   = 3'(VEC_WAIT);

    logic [4:0] pend_q;
    logic [4:0] aclr_q;
    logic [3:0] lvl_q;
    logic [3:0] hcnt_q;
    logic [3:0] target;
    logic [4:0] eligible;

    vstate_t    vstate;
    logic [3:0] va_q;
    logic [2:0] wcnt_q;
    logic [7:0] di_q;
    logic       enter_done;
    logic [3:0] done_lvl;
    logic [4:0] done_src;
    logic       unused_base;

    // One-hot source for an IRL level; zero when the level belongs to no 32X source
    function automatic logic [4:0] lvl_src(input logic [3:0] l);
        case (l)
            4'd14:   return 5'b10000;
            4'd12:   return 5'b01000;
            4'd10:   return 5'b00100;
            4'd8:    return 5'b00010;
            4'd6:    return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    assign eligible    = pend_q & (SRC_MASK | 5'b10000);
    assign PEND        = pend_q;
    assign IRL_N       = ~lvl_q;
    assign VBUS_DI     = di_q;
    assign VBUS_WAIT   = VBUS_REQ & (vstate != V_DONE);
    assign done_src    = lvl_src(done_lvl);
    assign unused_base = ^VEC_BASE[2:0];

    // Highest-priority eligible source wins; later assignments override earlier ones
    always_comb begin
        target = 4'd0;
        if (eligible[0]) target = 4'd6;
        if (eligible[1]) target = 4'd8;
        if (eligible[2]) target = 4'd10;
        if (eligible[3]) target = 4'd12;
        if (eligible[4]) target = 4'd14;
    end

    // Pending flags and held IRL level; a set beats any clear landing in the same cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
            lvl_q  <= '0;
            hcnt_q <= '0;
        end else if (CE_R && !RES_N) begin
            pend_q <= '0;
            lvl_q  <= '0;
            hcnt_q <= '0;
        end else if (EN && CE_R) begin
            pend_q <= SRC_EV | (pend_q & ~SRC_CLR & ~aclr_q);
            if (hcnt_q != 4'd0) begin
                hcnt_q <= hcnt_q - 4'd1;
            end else if (target != lvl_q) begin
                lvl_q  <= target;
                hcnt_q <= HOLD_RELOAD;
            end
        end
    end

    // Detects the CE_F on which the fetch reaches V_DONE and which level it answers
    always_comb begin
        enter_done = 1'b0;
        done_lvl   = va_q;
        if (CE_F) begin
            case (vstate)
                V_IDLE: if (VBUS_REQ && VEC_WAIT == 0) begin
                    enter_done = 1'b1;
                    done_lvl   = VBUS_A;
                end
                V_WAIT: if (VBUS_REQ && wcnt_q == 3'd1) enter_done = 1'b1;
                default: ;
            endcase
        end
    end

    // Vector fetch FSM; the auto-clear strobe lives until the next CE_R consumes it
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vstate <= V_IDLE;
            va_q   <= '0;
            wcnt_q <= '0;
            di_q   <= '0;
            aclr_q <= '0;
        end else if (CE_R && !RES_N) begin
            vstate <= V_IDLE;
            va_q   <= '0;
            wcnt_q <= '0;
            di_q   <= '0;
            aclr_q <= '0;
        end else begin
            if (CE_R) aclr_q <= '0;
            if (enter_done) begin
                vstate <= V_DONE;
                va_q   <= done_lvl;
                di_q   <= (done_src != 5'd0) ? {VEC_BASE[7:3], done_lvl[3:1]} : 8'h00;
                aclr_q <= (AUTO_CLR != 0) ? done_src : 5'd0;
            end else if (CE_F) begin
                case (vstate)
                    V_IDLE: if (VBUS_REQ) begin
                        va_q   <= VBUS_A;
                        wcnt_q <= WAIT_LOAD;
                        vstate <= V_WAIT;
                    end
                    V_WAIT: begin
                        if (!VBUS_REQ) vstate <= V_IDLE;
                        else           wcnt_q <= wcnt_q - 3'd1;
                    end
                    V_DONE: if (!VBUS_REQ) begin
                        vstate <= V_IDLE;
                        di_q   <= 8'h00;
                    end
                    default: vstate <= V_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_s32x_irl_sched.sv
// tb/tb_s32x_irl_sched.sv - randomized self-checking bench for s32x_irl_sched
module tb_s32x_irl_sched;

    localparam int HOLD_MIN = 4;
    localparam int VEC_WAIT = 1;
    localparam int AUTO_CLR = 1;

    logic       CLK = 1'b0;
    logic       RST_N, CE_R, CE_F, EN, RES_N, VBUS_REQ;
    logic [4:0] SRC_EV, SRC_MASK, SRC_CLR, PEND;
    logic [7:0] VEC_BASE, VBUS_DI;
    logic [3:0] IRL_N, VBUS_A;
    logic       VBUS_WAIT;

    s32x_irl_sched #(.HOLD_MIN(HOLD_MIN), .VEC_WAIT(VEC_WAIT), .AUTO_CLR(AUTO_CLR)) dut (
        .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .EN(EN), .RES_N(RES_N),
        .SRC_EV(SRC_EV), .SRC_MASK(SRC_MASK), .SRC_CLR(SRC_CLR), .VEC_BASE(VEC_BASE),
        .PEND(PEND), .IRL_N(IRL_N), .VBUS_A(VBUS_A), .VBUS_REQ(VBUS_REQ),
        .VBUS_DI(VBUS_DI), .VBUS_WAIT(VBUS_WAIT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: levels, priority and timing expressed directly from the rules
    bit [4:0] m_pend, m_aclr;
    int       m_lvl, m_held, m_ticks;
    bit       m_act, m_done;
    bit [3:0] m_va;
    bit [7:0] m_di;

    function automatic int src_level(int i);
        return 6 + 2 * i;
    endfunction

    function automatic int level_src(int l);
        for (int i = 0; i < 5; i++) if (src_level(i) == l) return i;
        return -1;
    endfunction

    function automatic int m_target();
        for (int i = 4; i >= 0; i--)
            if (m_pend[i] && (SRC_MASK[i] || i == 4)) return src_level(i);
        return 0;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_aclr = '0; m_lvl = 0; m_held = HOLD_MIN;
        m_act = 0; m_done = 0; m_ticks = 0; m_va = '0; m_di = '0;
    endtask

    task automatic model_edge();
        int tgt, idx;
        if (!RST_N || (CE_R && !RES_N)) begin
            model_reset();
            return;
        end
        if (CE_R && EN) begin
            tgt = m_target();
            if (m_held < HOLD_MIN) m_held++;
            if (m_held >= HOLD_MIN && tgt != m_lvl) begin
                m_lvl  = tgt;
                m_held = 0;
            end
            m_pend = SRC_EV | (m_pend & ~SRC_CLR & ~m_aclr);
        end
        if (CE_R) m_aclr = '0;
        if (CE_F) begin
            if (!m_act) begin
                if (VBUS_REQ) begin m_act = 1; m_ticks = 0; m_va = VBUS_A; end
            end else if (!m_done) begin
                if (!VBUS_REQ) m_act = 0;
                else           m_ticks++;
            end else if (!VBUS_REQ) begin
                m_act = 0; m_done = 0; m_di = '0;
            end
            if (m_act && !m_done && m_ticks == VEC_WAIT) begin
                m_done = 1;
                idx = level_src(int'(m_va));
                m_di = (idx >= 0) ? {VEC_BASE[7:3], m_va[3:1]} : 8'h00;
                if (AUTO_CLR != 0 && idx >= 0) m_aclr[idx] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] e_irl;
        e_irl = ~m_lvl[3:0];
        chk("pend", PEND, m_pend);
        chk("irl_n", IRL_N, e_irl);
        chk("vbus_di", VBUS_DI, m_di);
        chk("vbus_wait", VBUS_WAIT, VBUS_REQ && !m_done);
    endtask

    task automatic step();
        model_edge();
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic tick_r();
        CE_R = 1; CE_F = 0; step(); CE_R = 0;
    endtask

    task automatic tick_f();
        CE_R = 0; CE_F = 1; step(); CE_F = 0;
    endtask

    task automatic ticks_r(input int n);
        for (int i = 0; i < n; i++) tick_r();
    endtask

    task automatic pulse(input logic [4:0] ev, input logic [4:0] clr);
        SRC_EV = ev; SRC_CLR = clr; tick_r(); SRC_EV = '0; SRC_CLR = '0;
    endtask

    initial begin
        RST_N = 0; CE_R = 0; CE_F = 0; EN = 1; RES_N = 1;
        SRC_EV = '0; SRC_MASK = 5'b11111; SRC_CLR = '0; VEC_BASE = 8'h40;
        VBUS_A = '0; VBUS_REQ = 0;
        model_reset();
        tick_r(); tick_f();
        chk("reset_pend", PEND, 5'd0);
        chk("reset_irl", IRL_N, 4'hF);
        RST_N = 1;
        tick_r();

        // Single event, hold, then clear
        pulse(5'b01000, 5'b00000);
        chk("single_pend", PEND, 5'b01000);
        tick_r();
        chk("single_irl", IRL_N, 4'h3);
        ticks_r(3);
        chk("single_held", IRL_N, 4'h3);
        pulse(5'b00000, 5'b01000);
        ticks_r(HOLD_MIN + 1);
        chk("single_release", IRL_N, 4'hF);
        ticks_r(HOLD_MIN + 1);

        // Priority with hold
        pulse(5'b00100, 5'b00000);
        tick_r();
        chk("prio_h", IRL_N, 4'h5);
        pulse(5'b10000, 5'b00000);
        tick_r();
        chk("prio_hold", IRL_N, 4'h5);
        ticks_r(3);
        chk("prio_vres", IRL_N, 4'h1);
        pulse(5'b00000, 5'b10000);
        ticks_r(6);
        chk("prio_back", IRL_N, 4'h5);
        pulse(5'b00000, 5'b00100);
        ticks_r(6);

        // Masking
        SRC_MASK = 5'b11110;
        pulse(5'b00001, 5'b00000);
        ticks_r(6);
        chk("mask_off", IRL_N, 4'hF);
        chk("mask_pend", PEND, 5'b00001);
        SRC_MASK = 5'b11111;
        ticks_r(6);
        chk("mask_on", IRL_N, 4'h9);
        SRC_MASK = 5'b01111;
        pulse(5'b10000, 5'b00001);
        ticks_r(6);
        chk("mask_vres", IRL_N, 4'h1);
        pulse(5'b00000, 5'b10000);
        ticks_r(6);
        SRC_MASK = 5'b11111;

        // Vector fetch with auto-clear, then an invalid level
        pulse(5'b01000, 5'b00000);
        ticks_r(6);
        VBUS_A = 4'd12; VBUS_REQ = 1;
        #1;
        chk("vec_wait_comb", VBUS_WAIT, 1'b1);
        tick_f();
        chk("vec_wait_1", VBUS_WAIT, 1'b1);
        tick_f();
        chk("vec_di", VBUS_DI, 8'h46);
        chk("vec_wait_0", VBUS_WAIT, 1'b0);
        tick_r();
        chk("vec_aclr", PEND, 5'b00000);
        VBUS_REQ = 0; tick_f();
        pulse(5'b01000, 5'b00000);
        VBUS_A = 4'd3; VBUS_REQ = 1;
        tick_f(); tick_f();
        chk("vec_bad_di", VBUS_DI, 8'h00);
        tick_r();
        chk("vec_bad_noclr", PEND, 5'b01000);
        VBUS_REQ = 0; tick_f();
        pulse(5'b00000, 5'b01000);
        ticks_r(6);

        // Set/clear collision
        pulse(5'b00010, 5'b00010);
        chk("collide", PEND, 5'b00010);

        // Soft reset during HOLD and V_WAIT
        pulse(5'b00100, 5'b00000);
        tick_r();
        VBUS_A = 4'd10; VBUS_REQ = 1;
        tick_f();
        RES_N = 0;
        tick_r();
        chk("sres_pend", PEND, 5'd0);
        chk("sres_irl", IRL_N, 4'hF);
        chk("sres_di", VBUS_DI, 8'h00);
        VBUS_REQ = 0;
        #1;
        chk("sres_wait", VBUS_WAIT, 1'b0);
        RES_N = 1;
        tick_r();

        // Asynchronous reset between clock edges
        pulse(5'b01000, 5'b00000);
        tick_r();
        RST_N = 0;
        #2;
        chk("areset_pend", PEND, 5'd0);
        chk("areset_irl", IRL_N, 4'hF);
        model_reset();
        tick_r();
        RST_N = 1;

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            CE_R   = ($urandom % 3) == 0;
            CE_F   = ($urandom % 3) == 0;
            EN     = ($urandom % 8) != 0;
            RES_N  = ($urandom % 80) != 0;
            for (int b = 0; b < 5; b++) begin
                SRC_EV[b]  = ($urandom % 10) == 0;
                SRC_CLR[b] = ($urandom % 14) == 0;
            end
            if (($urandom % 50) == 0) SRC_MASK = 5'($urandom);
            if (($urandom % 60) == 0) VEC_BASE = 8'($urandom);
            if (!VBUS_REQ) begin
                if (($urandom % 8) == 0) begin
                    VBUS_REQ = 1;
                    case ($urandom % 7)
                        0: VBUS_A = 4'd14;
                        1: VBUS_A = 4'd12;
                        2: VBUS_A = 4'd10;
                        3: VBUS_A = 4'd8;
                        4: VBUS_A = 4'd6;
                        default: VBUS_A = 4'($urandom);
                    endcase
                end
            end else if (($urandom % 6) == 0) begin
                VBUS_REQ = 0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
